// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU with a start/busy/done handshake.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   reset_i    synchronous active-high reset; aborts any operation in flight
//   start_i    request, accepted on an edge where start_i=1 and busy_o=0
//   select_i   opcode, latched on accept
//   data1_i    operand A / shift source, latched on accept
//   data2_i    operand B / shift amount, latched on accept
//   busy_o     operation in progress; start_i is ignored while high
//   done_o     one-cycle pulse after result_o/carry_o have been updated
//   result_o   registered result, held until the next completion
//   zero_o     combinational (result_o == 0)
//   carry_o    registered carry / no-borrow / multiply-overflow flag
//   state_o    current FSM state, for debug and checker binding
//
// Handshake: an op is accepted on a rising edge with start_i=1 and
// busy_o=0. busy_o stays high until the edge that writes result_o/carry_o;
// done_o is high for the single cycle after that edge, and because busy_o
// is already low there a new start_i in that cycle is accepted.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic [1:0]       state_o
);

  localparam int LOG_W = $clog2(WIDTH);

  localparam logic [3:0] OP_FWD = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_ROR = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   n_eff;
  logic               is_shift;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     mul_sum;

  assign is_shift = (select_i == OP_SLL) || (select_i == OP_SRL) ||
                    (select_i == OP_SRA) || (select_i == OP_ROR);

  // Linear shifts saturate at WIDTH (which naturally flushes to all-zero or
  // all-sign); rotates wrap, so only the low LOG_W bits of the amount matter.
  always_comb begin
    n_eff = '0;
    if (select_i == OP_ROR) begin
      n_eff = CNT_W'(data2_i[LOG_W-1:0]);
    end else if (data2_i >= WIDTH_V) begin
      n_eff = WIDTH_C;
    end else begin
      n_eff = CNT_W'(data2_i);
    end
  end

  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  // Shift-add step: acc holds {partial product high half, remaining multiplier}.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = select_i;
          a_d   = data1_i;
          b_d   = data2_i;
          acc_d = {{WIDTH{1'b0}}, data2_i};
          if (select_i == OP_MUL) begin
            cnt_d   = WIDTH_C;
            state_d = S_MUL;
          end else if (is_shift && (n_eff != '0)) begin
            cnt_d   = n_eff;
            state_d = S_SHIFT;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_SLL:  a_d = {a_q[WIDTH-2:0], 1'b0};
          OP_SRL:  a_d = {1'b0, a_q[WIDTH-1:1]};
          OP_SRA:  a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          default: a_d = {a_q[0], a_q[WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) state_d = S_EXEC;
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) state_d = S_EXEC;
      end
      default: begin
        carry_d = 1'b0;
        case (op_q)
          OP_FWD: result_d = b_q;
          OP_ADD: begin
            result_d = add_sum[WIDTH-1:0];
            carry_d  = add_sum[WIDTH];
          end
          OP_SUB: begin
            result_d = a_q - b_q;
            carry_d  = (a_q >= b_q);
          end
          OP_AND: result_d = a_q & b_q;
          OP_OR:  result_d = a_q | b_q;
          OP_XOR: result_d = a_q ^ b_q;
          OP_SLL, OP_SRL, OP_SRA, OP_ROR: result_d = a_q;
          OP_MUL: begin
            result_d = acc_q[WIDTH-1:0];
            carry_d  = |acc_q[2*WIDTH-1:WIDTH];
          end
          default: result_d = '0;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);
  assign carry_o  = carry_q;
  assign state_o  = state_q;

endmodule
